// File: rtl/regfile_alu_seq.sv
// Register file with a four-state operand-read / execute / write-back sequencer around an ALU.
// Host load port preloads registers while idle; the debug port reads any register combinationally.
//
// state  | meaning
// S_IDLE | waiting; start latches the request, ld_we writes the register file
// S_READ | register operands fetched into A/B
// S_EXEC | ALU result and flags registered
// S_WB   | result written to wa3, done pulses
module regfile_alu_seq #(
    parameter int WIDTH    = 8,
    parameter int NREGS    = 8,
    parameter bit ZERO_REG = 1'b1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    input  logic [AW-1:0]    wa3,
    input  logic             use_imm,
    input  logic [WIDTH-1:0] imm,
    input  logic             ld_we,
    input  logic [AW-1:0]    ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    input  logic [AW-1:0]    dbg_ra,
    output logic [WIDTH-1:0] dbg_rd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v
);
    localparam int SW = $clog2(WIDTH);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  regs_q [NREGS];
    logic [WIDTH-1:0]  regs_d [NREGS];
    logic [2:0]        op_q, op_d;
    logic [AW-1:0]     ra1_q, ra1_d, ra2_q, ra2_d, wa3_q, wa3_d;
    logic              use_imm_q, use_imm_d;
    logic [WIDTH-1:0]  imm_q, imm_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;

    logic [WIDTH-1:0]  rd_a, rd_b;
    logic [WIDTH-1:0]  alu_res;
    logic              alu_c, alu_v;
    logic [WIDTH:0]    sum, diff;
    logic [SW-1:0]     sh;

    // Register 0 is masked on read as well, so it reads 0 whatever the array holds.
    assign rd_a   = (ZERO_REG && ra1_q == '0) ? '0 : regs_q[ra1_q];
    assign rd_b   = (ZERO_REG && ra2_q == '0) ? '0 : regs_q[ra2_q];
    assign dbg_rd = (ZERO_REG && dbg_ra == '0) ? '0 : regs_q[dbg_ra];

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_WB);
    assign result = result_q;
    assign flag_z = z_q;
    assign flag_n = n_q;
    assign flag_c = c_q;
    assign flag_v = v_q;

    always_comb begin
        sum     = {1'b0, a_q} + {1'b0, b_q};
        diff    = {1'b0, a_q} - {1'b0, b_q};
        sh      = b_q[SW-1:0];
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_q)
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_XOR: alu_res = a_q ^ b_q;
            OP_SLL: alu_res = a_q << sh;
            OP_SRL: alu_res = a_q >> sh;
            OP_SUB: begin
                // Carry means no borrow, i.e. A >= B unsigned.
                alu_res = diff[WIDTH-1:0];
                alu_c   = ~diff[WIDTH];
                alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SLT: alu_res[0] = ($signed(a_q) < $signed(b_q));
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        regs_d    = regs_q;
        op_d      = op_q;
        ra1_d     = ra1_q;
        ra2_d     = ra2_q;
        wa3_d     = wa3_q;
        use_imm_d = use_imm_q;
        imm_d     = imm_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        z_d       = z_q;
        n_d       = n_q;
        c_d       = c_q;
        v_d       = v_q;
        case (state_q)
            S_IDLE: begin
                if (ld_we && !(ZERO_REG && ld_addr == '0)) begin
                    regs_d[ld_addr] = ld_data;
                end
                if (start) begin
                    op_d      = op;
                    ra1_d     = ra1;
                    ra2_d     = ra2;
                    wa3_d     = wa3;
                    use_imm_d = use_imm;
                    imm_d     = imm;
                    state_d   = S_READ;
                end
            end
            S_READ: begin
                a_d     = rd_a;
                b_d     = use_imm_q ? imm_q : rd_b;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                result_d = alu_res;
                z_d      = (alu_res == '0);
                n_d      = alu_res[WIDTH-1];
                c_d      = alu_c;
                v_d      = alu_v;
                state_d  = S_WB;
            end
            S_WB: begin
                if (!(ZERO_REG && wa3_q == '0)) begin
                    regs_d[wa3_q] = result_q;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            regs_q    <= '{default: '0};
            op_q      <= '0;
            ra1_q     <= '0;
            ra2_q     <= '0;
            wa3_q     <= '0;
            use_imm_q <= 1'b0;
            imm_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            z_q       <= 1'b0;
            n_q       <= 1'b0;
            c_q       <= 1'b0;
            v_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            regs_q    <= regs_d;
            op_q      <= op_d;
            ra1_q     <= ra1_d;
            ra2_q     <= ra2_d;
            wa3_q     <= wa3_d;
            use_imm_q <= use_imm_d;
            imm_q     <= imm_d;
            a_q       <= a_d;
            b_q       <= b_d;
            result_q  <= result_d;
            z_q       <= z_d;
            n_q       <= n_d;
            c_q       <= c_d;
            v_q       <= v_d;
        end
    end
endmodule
